// File: rtl/cci_mpf_prim_buffer_lockstep_nch.sv
//
// cci_mpf_prim_buffer_lockstep_nch
//
// Lockstep request buffer. Each FIFO entry carries N_CHANNELS payloads
// together with a per-channel valid mask. Requests that arrive in the same
// cycle therefore leave in the same relative order. The consumer can retire
// channels of the head entry one at a time (deq_ch) or drop the whole head
// entry at once (deq_all). The head entry is popped when its last remaining
// valid channel is consumed.
//
// Ports
//   clk           sole clock, rising edge
//   reset_n       asynchronous, active-low reset
//   enq_data      N_CHANNELS x DATA_BITS payload; channel i is [i*DATA_BITS +: DATA_BITS]
//   enq_valid     per-channel valid; an entry is written when any bit is set
//   not_full      room for at least one more entry
//   almost_full   free slots <= THRESHOLD
//   first_data    payload of the head entry
//   first_valid   channels of the head entry not yet consumed (0 when empty)
//   not_empty     at least one entry is buffered
//   deq_all       pop the head entry regardless of its remaining valids
//   deq_ch        consume individual channels of the head entry
//   count         current occupancy
//   overflow_err  sticky: an enqueue was attempted while full
//   underflow_err sticky: a dequeue was attempted on an empty buffer or
//                 on a channel that is not valid at the head
//
module cci_mpf_prim_buffer_lockstep_nch #(
   parameter int N_CHANNELS = 2,
   parameter int DATA_BITS  = 64,
   parameter int THRESHOLD  = 8,
   parameter int N_ENTRIES  = THRESHOLD + 2
) (
   input  logic                               clk,
   input  logic                               reset_n,

   input  logic [N_CHANNELS*DATA_BITS-1:0]    enq_data,
   input  logic [N_CHANNELS-1:0]              enq_valid,
   output logic                               not_full,
   output logic                               almost_full,

   output logic [N_CHANNELS*DATA_BITS-1:0]    first_data,
   output logic [N_CHANNELS-1:0]              first_valid,
   output logic                               not_empty,
   input  logic                               deq_all,
   input  logic [N_CHANNELS-1:0]              deq_ch,

   output logic [$clog2(N_ENTRIES+1)-1:0]     count,
   output logic                               overflow_err,
   output logic                               underflow_err
);

   localparam int CW = $clog2(N_ENTRIES + 1);
   localparam int PW = $clog2(N_ENTRIES);

   logic [N_CHANNELS*DATA_BITS-1:0] mem [N_ENTRIES];
   logic [N_CHANNELS-1:0]           vmask [N_ENTRIES];

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;

   logic                  enq;
   logic                  push;
   logic                  pop;
   logic                  deq_any;
   logic                  partial_upd;
   logic                  overflow_set;
   logic                  underflow_set;
   logic [N_CHANNELS-1:0] head_mask;
   logic [N_CHANNELS-1:0] legal;
   logic [N_CHANNELS-1:0] remain;

   // Pointers wrap at N_ENTRIES, so the depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(N_ENTRIES - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // All status outputs come from the registered count, so there is no
   // combinational path from enq/deq inputs to any output.
   always_comb begin
      not_empty   = (count != '0);
      not_full    = (count < CW'(N_ENTRIES));
      almost_full = ((CW'(N_ENTRIES) - count) <= CW'(THRESHOLD));
      head_mask   = vmask[rd_ptr];
      first_data  = mem[rd_ptr];
      first_valid = head_mask & {N_CHANNELS{not_empty}};
   end

   // Push/pop decisions for this cycle. Full is judged on the registered
   // count, so a dequeue in the same cycle does not make room. deq_all takes
   // priority over deq_ch. An empty buffer never bypasses, because
   // first_valid is zero while empty.
   always_comb begin
      enq           = |enq_valid;
      push          = enq & not_full;
      deq_any       = deq_all | (|deq_ch);
      legal         = deq_ch & first_valid;
      remain        = head_mask & ~legal;
      partial_upd   = not_empty & ~deq_all & (|legal);
      pop           = not_empty & (deq_all | ((|legal) & (remain == '0)));
      overflow_set  = enq & ~not_full;
      underflow_set = (deq_any & ~not_empty) |
                      (~deq_all & (|(deq_ch & ~first_valid)));
   end

   // Payload storage has no reset. A slot only becomes visible after it has
   // been written, so stale contents are never observed as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= enq_data;
      end
   end

   // Valid masks, pointers, occupancy and sticky error flags. The write slot
   // and the head slot coincide only when the buffer is empty or full. Neither
   // case allows both a push and a head update, so the two writes to vmask
   // never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_ENTRIES; i++) begin
            vmask[i] <= '0;
         end
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end
      else begin
         if (partial_upd) begin
            vmask[rd_ptr] <= remain;
         end
         if (push) begin
            vmask[wr_ptr] <= enq_valid;
            wr_ptr        <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         count <= count + CW'(push) - CW'(pop);
         if (overflow_set) begin
            overflow_err <= 1'b1;
         end
         if (underflow_set) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
